// File: rtl/riscv_regfile_mp.sv
// Multi-read-port integer register file with post-reset clear sequencer and registered read-valid flags.
// Optional write-to-read forwarding is enabled by defining RISCV_REGFILE_BYPASS_EN.
module riscv_regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        i_re,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  output logic [NUM_RD-1:0]        o_rvalid,
  output logic                     o_busy
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W = ADDR_W + 1;
  localparam logic [CMP_W-1:0]  DEPTH_C = CMP_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                    state, state_next;
  logic [ADDR_W-1:0]         cnt, cnt_next;
  logic [DATA_W-1:0]         mem [DEPTH];
  logic                      wr_en;
  logic [NUM_RD*DATA_W-1:0]  rd_nxt;

  // Address maps to an implemented, writable/readable entry (entry 0 excluded when hardwired).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == ST_CLEAR) begin
      cnt_next = cnt + ADDR_W'(1);
      if (cnt == LAST) begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end
    end
  end

  // Busy flop mirrors the state register so it is high exactly while clearing.
  always_ff @(posedge clk) begin
    if (rst) o_busy <= 1'b1;
    else     o_busy <= (state_next == ST_CLEAR);
  end

  assign wr_en = !rst && (state == ST_RUN) && i_we && addr_ok(i_waddr);

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)  mem[IDX_W'(cnt)]     <= '0;
    else if (wr_en)         mem[IDX_W'(i_waddr)] <= i_wdata;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              fwd;
    assign ra = i_raddr[k*ADDR_W +: ADDR_W];
`ifdef RISCV_REGFILE_BYPASS_EN
    assign fwd = wr_en && i_re[k] && (ra == i_waddr);
`else
    assign fwd = 1'b0;
`endif
    assign rd_nxt[k*DATA_W +: DATA_W] = fwd ? i_wdata :
                                        (i_re[k] && addr_ok(ra)) ? mem[IDX_W'(ra)] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || state != ST_RUN) begin
      o_rdata  <= '0;
      o_rvalid <= '0;
    end else begin
      o_rdata  <= rd_nxt;
      o_rvalid <= i_re;
    end
  end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Directed bench for riscv_regfile_mp: default 32x32/2-port instance plus a 64-bit/16-entry/3-port instance.
module tb_riscv_regfile_mp;

`ifdef RISCV_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  i_re = '0;
  logic [9:0]  i_raddr = '0;
  logic        i_we = 1'b0;
  logic [4:0]  i_waddr = '0;
  logic [31:0] i_wdata = '0;
  logic [63:0] o_rdata;
  logic [1:0]  o_rvalid;
  logic        o_busy;

  logic         rst6 = 1'b1;
  logic [2:0]   re6 = '0;
  logic [14:0]  raddr6 = '0;
  logic         we6 = 1'b0;
  logic [4:0]   waddr6 = '0;
  logic [63:0]  wdata6 = '0;
  logic [191:0] rdata6;
  logic [2:0]   rvalid6;
  logic         busy6;

  riscv_regfile_mp u_dut (
    .clk(clk), .rst(rst), .i_re(i_re), .i_raddr(i_raddr), .i_we(i_we),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_rvalid(o_rvalid), .o_busy(o_busy)
  );

  riscv_regfile_mp #(.DATA_W(64), .ADDR_W(5), .DEPTH(16), .NUM_RD(3), .ZERO_REG(1)) u_dut6 (
    .clk(clk), .rst(rst6), .i_re(re6), .i_raddr(raddr6), .i_we(we6),
    .i_waddr(waddr6), .i_wdata(wdata6), .o_rdata(rdata6),
    .o_rvalid(rvalid6), .o_busy(busy6)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e0, e1;
    logic [1:0]  ev;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    i_re = re; i_raddr = {ra1, ra0}; i_we = we; i_waddr = wa; i_wdata = wd;
    @(posedge clk); @(negedge clk);
  endtask

  // Counts consecutive busy cycles from the current negedge; also flags any non-zero read output.
  task automatic count_busy(output int n, output int bad);
    n = 0; bad = 0;
    while (o_busy === 1'b1 && n < 100) begin
      if (o_rvalid !== 2'b00 || o_rdata !== 64'h0) bad++;
      n++;
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    int n, bad;

    vecs[0]  = '{2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0,    32'h0, 32'h0, 2'b01};
    vecs[1]  = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 32'h0, 32'h0, 2'b00};
    vecs[2]  = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd5, 32'hCAFE, 32'h0, 32'h0, 2'b00};
    vecs[3]  = '{2'b11, 5'd0, 5'd5, 1'b0, 5'd0, 32'h0,    32'h0, 32'hCAFE, 2'b11};
    vecs[4]  = '{2'b01, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0,    32'hCAFE, 32'h0, 2'b01};
    vecs[5]  = '{2'b00, 5'd0, 5'd0, 1'b1, 5'd7, 32'h11,   32'h0, 32'h0, 2'b00};
    vecs[6]  = '{2'b11, 5'd7, 5'd7, 1'b1, 5'd7, 32'h22,
                 BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11, 2'b11};
    vecs[7]  = '{2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0,    32'h22, 32'h22, 2'b11};
    vecs[8]  = '{2'b01, 5'd0, 5'd0, 1'b1, 5'd0, 32'h55,   32'h0, 32'h0, 2'b01};
    vecs[9]  = '{2'b11, 5'd9, 5'd7, 1'b1, 5'd9, 32'hAB,   BYP ? 32'hAB : 32'h0, 32'h22, 2'b11};
    vecs[10] = '{2'b11, 5'd1, 5'd9, 1'b0, 5'd0, 32'h0,    32'h0, 32'hAB, 2'b11};

    // Reset state, then clear with a write attempt held throughout.
    @(posedge clk); @(negedge clk);
    check("reset_busy", 64'(o_busy), 64'h1);
    check("reset_rvalid", 64'(o_rvalid), 64'h0);
    check("reset_rdata", o_rdata, 64'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    i_we = 1'b1; i_waddr = 5'd3; i_wdata = 32'hDEAD; i_re = 2'b11; i_raddr = {5'd3, 5'd3};
    count_busy(n, bad);
    i_we = 1'b0; i_re = 2'b00;
    check("clear_busy_cycles", 64'(n), 64'd32);
    check("clear_outputs_zero", 64'(bad), 64'd0);

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].re, vecs[i].ra0, vecs[i].ra1, vecs[i].we, vecs[i].wa, vecs[i].wd);
      check($sformatf("vec%0d_rdata0", i), 64'(o_rdata[31:0]), 64'(vecs[i].e0));
      check($sformatf("vec%0d_rdata1", i), 64'(o_rdata[63:32]), 64'(vecs[i].e1));
      check($sformatf("vec%0d_rvalid", i), 64'(o_rvalid), 64'(vecs[i].ev));
    end

    // Populate high entries, then reset mid-clear and confirm a full restart.
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd20, 32'h77);
    step(2'b00, 5'd0, 5'd0, 1'b1, 5'd31, 32'h88);
    step(2'b11, 5'd20, 5'd31, 1'b0, 5'd0, 32'h0);
    check("pre_reset_r20", 64'(o_rdata[31:0]), 64'h77);
    check("pre_reset_r31", 64'(o_rdata[63:32]), 64'h88);
    i_re = 2'b00;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    count_busy(n, bad);
    check("midclear_busy_cycles", 64'(n), 64'd32);
    check("midclear_outputs_zero", 64'(bad), 64'd0);
    for (int i = 0; i < 32; i++) begin
      step(2'b11, 5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0);
      check($sformatf("post_clear_p0_r%0d", i), 64'(o_rdata[31:0]), 64'h0);
      check($sformatf("post_clear_p1_r%0d", 31 - i), 64'(o_rdata[63:32]), 64'h0);
    end
    i_re = 2'b00;

    // Wide, shallow, three-port instance.
    rst6 = 1'b0;
    n = 0;
    while (busy6 === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); @(negedge clk);
    end
    check("p6_busy_cycles", 64'(n), 64'd16);
    we6 = 1'b1; waddr6 = 5'd15; wdata6 = 64'hFFFF_0000_0000_0001; re6 = 3'b000;
    @(posedge clk); @(negedge clk);
    we6 = 1'b1; waddr6 = 5'd20; wdata6 = 64'h5555_5555_5555_5555;
    re6 = 3'b111; raddr6 = {5'd15, 5'd15, 5'd15};
    @(posedge clk); @(negedge clk);
    check("p6_r15_port0", rdata6[63:0],    64'hFFFF_0000_0000_0001);
    check("p6_r15_port1", rdata6[127:64],  64'hFFFF_0000_0000_0001);
    check("p6_r15_port2", rdata6[191:128], 64'hFFFF_0000_0000_0001);
    check("p6_rvalid", 64'(rvalid6), 64'h7);
    we6 = 1'b0; re6 = 3'b111; raddr6 = {5'd15, 5'd4, 5'd20};
    @(posedge clk); @(negedge clk);
    check("p6_oob_read", rdata6[63:0], 64'h0);
    check("p6_r4_no_alias", rdata6[127:64], 64'h0);
    check("p6_r15_again", rdata6[191:128], 64'hFFFF_0000_0000_0001);
    re6 = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
